c_result_drain: RTL
===================

Name: c_result_drain

Overview:
- Unload side of the systolic-array datapath: on a start pulse, snapshots the full N x N result matrix C, then streams it out one element per handshake over a valid/ready interface.
- Elements leave in row-major order, tagged with row/column indices and a last flag.
- Sits between the array's parallel C output and the downstream writeback path, so the array can start the next operand load while results drain.

Parameters:
- N, 16, matrix dimension (rows = columns); N >= 2.
- W, 16, result element width in bits.
- IW, 4, index width for out_row/out_col; must satisfy 2^IW >= N.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous reset, active-high.
- start  input  1  single-cycle request to capture c_flat and begin draining.
- c_flat  input  N*N*W  flattened C; element k = row*N+col at c_flat[k*W +: W].
- busy  output  1  high from the capture edge until the final handshake.
- done  output  1  one-cycle pulse in the cycle after the final handshake.
- out_valid  output  1  out_data/out_row/out_col/out_last are valid.
- out_ready  input  1  downstream accepts the element when high together with out_valid.
- out_data  output  W  current element value.
- out_row  output  IW  row index of the current element.
- out_col  output  IW  column index of the current element.
- out_last  output  1  high only on element (N-1, N-1).

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset: state IDLE; busy, done, out_valid and out_last = 0; out_data, out_row, out_col = 0; snapshot contents don't-care. Reset mid-stream abandons the transfer with no done pulse.
- States:
  - IDLE: start=1 at edge T loads the whole c_flat into the snapshot, sets row=col=0 and enters STREAM. out_valid=1 and busy=1 from the cycle after T.
  - STREAM: out_data = snapshot[(row*N+col)*W +: W]. Outputs are registered or driven directly from registered state and snapshot. No combinational path from out_ready to any output.
- Handshake:
  - A transfer occurs on an edge where out_valid && out_ready.
  - Without a transfer, all out_* signals hold stable. A valid element is never withdrawn or changed before it is accepted.
  - On a transfer: col increments. When col == N-1, col wraps to 0 and row increments.
  - On a transfer with out_last=1 (row == col == N-1): next cycle state=IDLE, out_valid=0, busy=0, done=1 for exactly one cycle, row/col reset to 0.
- Throughput: one element per cycle while out_ready stays high. Total N*N transfers; minimum time from start edge to done is N*N+1 cycles.
- start while busy is ignored; the snapshot is not overwritten. start in the done cycle is accepted (state is already IDLE).
- c_flat is sampled only at the capture edge. Later changes to c_flat do not affect the stream.
- out_last = (row==N-1) && (col==N-1) && out_valid.
- Indices are zero-extended to IW. The element width is passed through unchanged; no arithmetic is done on data.

Test Plan:
- Reset/idle: hold rst 3 cycles, then release with start=0 -> busy=0, out_valid=0, done=0 for 20 cycles.
- Full drain, default N=16/W=16: c_flat element (r,c) = (r+1)*(c+1); pulse start; out_ready=1 constant.
  - 256 transfers in row-major order; first element (0,0)=1; element (3,5)=24; last element (15,15)=256 with out_last=1.
  - done pulses exactly 257 cycles after the start edge.
- Backpressure: same data, out_ready toggles 1,0,0,1 repeating.
  - While out_ready=0, out_data/out_row/out_col stay unchanged.
  - Sequence identical to the full-drain test; transfer count = 256.
- Snapshot isolation: after the start edge, overwrite c_flat with all 16'hFFFF -> streamed values still match the captured (r+1)*(c+1).
- start while busy: pulse start at transfer 100 with a different c_flat -> no restart, indices continue at (6,4), exactly one done.
- Reset mid-stream and back-to-back, N=4 instance:
  - Assert rst after 5 transfers -> next cycle out_valid=0, busy=0, no done.
  - Then start in the cycle after the first stream's done pulse -> second stream begins at (0,0) without a gap beyond one cycle.

Source files
------------

// File: rtl/c_result_drain.sv
// ---------------------------------------------------------------------------
// c_result_drain
//
// Unload stage for the systolic array. A start pulse copies the whole N x N
// result matrix C into a local snapshot, so the array is free to begin its
// next operand load right away. The snapshot is then streamed out one element
// per valid/ready handshake, in row-major order, with row/column tags and a
// last flag on element (N-1, N-1).
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset; abandons any stream, no done
//   start      one-cycle capture request, ignored while busy
//   c_flat     flattened C, element row*N+col at c_flat[(row*N+col)*W +: W]
//   busy       high from the capture edge until the final handshake
//   done       one-cycle pulse in the cycle after the final handshake
//   out_valid  current element is valid
//   out_ready  downstream accepts the element when high with out_valid
//   out_data   element value
//   out_row    row index of the element, zero-extended to IW
//   out_col    column index of the element, zero-extended to IW
//   out_last   high only on element (N-1, N-1)
// ---------------------------------------------------------------------------
module c_result_drain #(
    parameter int N  = 16,
    parameter int W  = 16,
    parameter int IW = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [N*N*W-1:0]   c_flat,
    output logic               busy,
    output logic               done,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       out_data,
    output logic [IW-1:0]      out_row,
    output logic [IW-1:0]      out_col,
    output logic               out_last
);

    localparam int EW = $clog2(N * N);

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [W-1:0]  snapshot [N*N];
    logic [IW-1:0] row;
    logic [IW-1:0] col;
    logic          done_q;
    logic [EW-1:0] elem;
    logic          capture;
    logic          fire;
    logic          at_last;
    logic          col_wrap;

    // Next-state logic and handshake qualifiers. Every output below depends
    // only on registered state and the snapshot, never on out_ready.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        fire       = 1'b0;
        col_wrap   = (col == IW'(N - 1));
        at_last    = (row == IW'(N - 1)) && col_wrap;
        unique case (state)
            IDLE: begin
                capture = start;
                if (start) begin
                    state_next = STREAM;
                end
            end
            STREAM: begin
                fire = out_ready;
                if (out_ready && at_last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Row/column walk. After the final element both indices return to 0 so
    // the next capture always begins at (0,0).
    always_ff @(posedge clk) begin
        if (rst) begin
            row    <= '0;
            col    <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= fire && at_last;
            if (capture) begin
                row <= '0;
                col <= '0;
            end else if (fire) begin
                if (at_last) begin
                    row <= '0;
                    col <= '0;
                end else if (col_wrap) begin
                    col <= '0;
                    row <= row + 1'b1;
                end else begin
                    col <= col + 1'b1;
                end
            end
        end
    end

    // The snapshot needs no reset: it is always reloaded before it is read.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k < N * N; k++) begin
                snapshot[k] <= c_flat[k*W +: W];
            end
        end
    end

    assign elem      = EW'(row) * EW'(N) + EW'(col);
    assign out_valid = (state == STREAM);
    assign busy      = (state == STREAM);
    assign done      = done_q;
    assign out_row   = row;
    assign out_col   = col;
    assign out_last  = out_valid && at_last;
    assign out_data  = out_valid ? snapshot[elem] : '0;

endmodule
